// File: rtl/usr_sequencer_if.sv
// Command channel into usr_sequencer: valid/ready handshake carrying op, step count and data.
// The master drives the command and the slave (the sequencer) returns ready.
interface usr_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_amt;
  logic [3:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_amt,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_amt,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/usr_sequencer.sv
// Drives a 4-bit always-shifting universal shift register through mode sequences.
// Between commands it rotates the stored word and flags the aligned phase.
module usr_sequencer (
  input  logic           clk,
  input  logic           reset,
  usr_sequencer_if.slave cmd,
  input  logic [3:0]     usr_q,
  output logic [2:0]     usr_mode,
  output logic           usr_data_in,
  output logic [3:0]     usr_pin,
  output logic           aligned,
  output logic [3:0]     word_out,
  output logic           busy,
  output logic           done
);

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  typedef enum logic [1:0] {
    OP_SHIFT_ZERO = 2'b00,
    OP_LOAD       = 2'b01,
    OP_ROTATE     = 2'b10,
    OP_SHIFT_IN   = 2'b11
  } op_t;

  state_t     r_state;
  op_t        r_op;
  logic [1:0] r_phase;
  logic [1:0] r_cnt;
  logic [3:0] r_data;
  logic [3:0] r_word_out;
  logic       r_done;

  logic       w_aligned;
  logic       w_ready;
  op_t        w_cmd_op;

  // The USR rotates once per idle cycle, so it matches the logical word only at phase 0.
  assign w_aligned = (r_state == ST_IDLE) && (r_phase == 2'd0);
  assign w_ready   = (r_state == ST_IDLE) && (r_phase == 2'd3);
  assign w_cmd_op  = op_t'(cmd.cmd_op);

  // NOTE: every register here is state, so it is assigned with <= only; blocking
  // assignments would make the result depend on statement order within the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_SHIFT_ZERO;
      r_phase    <= 2'd0;
      r_cnt      <= 2'd0;
      r_data     <= 4'd0;
      r_word_out <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_aligned) r_word_out <= usr_q;
      case (r_state)
        ST_IDLE: begin
          r_phase <= r_phase + 2'd1;
          if (w_ready && cmd.cmd_valid) begin
            r_state <= ST_EXEC;
            r_op    <= w_cmd_op;
            r_data  <= cmd.cmd_data;
            r_cnt   <= (w_cmd_op == OP_LOAD) ? 2'd3 : cmd.cmd_amt;
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd0) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    usr_mode    = 3'd2;
    usr_data_in = 1'b0;
    if (r_state == ST_EXEC) begin
      case (r_op)
        OP_SHIFT_ZERO: usr_mode = 3'd0;
        OP_LOAD:       usr_mode = {1'b1, r_cnt};
        OP_ROTATE:     usr_mode = 3'd2;
        OP_SHIFT_IN: begin
          usr_mode    = 3'd3;
          usr_data_in = r_data[r_cnt];
        end
        default:       usr_mode = 3'd2;
      endcase
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign usr_pin       = r_data;
  assign aligned       = w_aligned;
  assign word_out      = r_word_out;
  assign busy          = (r_state == ST_EXEC);
  assign done          = r_done;

endmodule
